// File: rtl/adc_sdram_pkg.sv
// Shared constants for the ADC-to-SDRAM capture client: FSM state codes and
// SDRAM word / address widths.
package adc_sdram_pkg;
  localparam int SDRAM_DW       = 16;
  localparam int DEF_ADDR_WIDTH = 22;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CAPTURE = 3'd1;
  localparam logic [2:0] WR_ACK  = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_ACK  = 3'd4;
  localparam logic [2:0] RD_WAIT = 3'd5;
  localparam logic [2:0] RD_OUT  = 3'd6;
endpackage

// File: rtl/adc_sdram_capture_client_sample_fifo.sv
// Synchronous sample FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module sample_fifo
  import adc_sdram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = SDRAM_DW
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge Clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/adc_sdram_capture_client.sv
// Captures a burst of ADC samples into SDRAM through the controller's
// Req/Ack/Busy port, then streams them back out on Dump.
module adc_sdram_capture_client
  import adc_sdram_pkg::*;
#(
  parameter int                    ADC_WIDTH  = 12,
  parameter int                    FIFO_DEPTH = 16,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADC_WIDTH-1:0]  AdcData,
  input  logic                  AdcValid,
  input  logic                  Arm,
  input  logic [ADDR_WIDTH-1:0] CaptureLen,
  input  logic                  Dump,
  output logic [15:0]           OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  Done,
  output logic                  Overflow,
  output logic                  Active,
  output logic                  MemReq,
  output logic                  MemWnR,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [15:0]           MemDataOut,
  input  logic [15:0]           MemDataIn,
  input  logic                  MemBusy,
  input  logic                  MemAck
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_acc_cnt;
  logic [ADDR_WIDTH-1:0] r_rd_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_req;
  logic                  r_mem_wnr;
  logic [15:0]           r_mem_dout;
  logic [15:0]           r_out_data;
  logic                  r_out_valid;
  logic                  r_done;
  logic                  r_overflow;

  logic [SDRAM_DW-1:0]   w_sample;
  logic [SDRAM_DW-1:0]   w_fifo_dout;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_intake;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_cap_end;
  logic [ADDR_WIDTH-1:0] w_rd_next;

  assign w_sample  = SDRAM_DW'(AdcData);
  // Intake stays open while a write is in flight so samples queue up behind it.
  assign w_intake  = ((r_state == CAPTURE) || (r_state == WR_ACK)) && AdcValid && (r_acc_cnt < r_len);
  assign w_pop     = (r_state == CAPTURE) && !w_fifo_empty && !MemBusy;
  assign w_push    = w_intake && (!w_fifo_full || w_pop);
  assign w_drop    = w_intake && w_fifo_full && !w_pop;
  // Every sample is either written or dropped, so nothing accepted-but-pending means finished.
  assign w_cap_end = (r_acc_cnt == r_len) && (w_fifo_count == '0);
  assign w_rd_next = r_rd_cnt + ADDR_WIDTH'(1);

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SDRAM_DW)) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_din   (w_sample),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_acc_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_mem_addr  <= START_ADDR;
      r_mem_req   <= 1'b0;
      r_mem_wnr   <= 1'b0;
      r_mem_dout  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_intake) r_acc_cnt  <= r_acc_cnt + ADDR_WIDTH'(1);
      if (w_drop)   r_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (Arm) begin
            if (CaptureLen != '0) begin
              r_state    <= CAPTURE;
              r_overflow <= 1'b0;
              r_len      <= CaptureLen;
              r_mem_addr <= START_ADDR;
              r_acc_cnt  <= '0;
              r_rd_cnt   <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end else if (Dump) begin
            if (r_len != '0) begin
              r_state    <= RD_REQ;
              r_mem_addr <= START_ADDR;
              r_rd_cnt   <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (w_pop) begin
            r_mem_dout <= w_fifo_dout;
            r_mem_req  <= 1'b1;
            r_mem_wnr  <= 1'b1;
            r_state    <= WR_ACK;
          end
        end
        WR_ACK: begin
          if (MemAck) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            if (w_cap_end) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= CAPTURE;
            end
          end
        end
        RD_REQ: begin
          if (!MemBusy) begin
            r_mem_req <= 1'b1;
            r_mem_wnr <= 1'b0;
            r_state   <= RD_ACK;
          end
        end
        RD_ACK: begin
          if (MemAck) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            r_state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Controller presents read data in its first idle cycle after the ack.
          if (!MemBusy) begin
            r_out_data  <= MemDataIn;
            r_out_valid <= 1'b1;
            r_state     <= RD_OUT;
          end
        end
        RD_OUT: begin
          if (r_out_valid && OutReady) begin
            r_out_valid <= 1'b0;
            r_rd_cnt    <= w_rd_next;
            if (w_rd_next < r_len) begin
              r_state <= RD_REQ;
            end else begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MemReq     = r_mem_req;
  assign MemWnR     = r_mem_wnr;
  assign MemAddress = r_mem_addr;
  assign MemDataOut = r_mem_dout;
  assign OutData    = r_out_data;
  assign OutValid   = r_out_valid;
  assign Done       = r_done;
  assign Overflow   = r_overflow;
  assign Active     = (r_state != IDLE);
endmodule

// File: tb/tb_adc_sdram_capture_client.sv
// Scoreboard bench: a behavioural SDRAM controller and sample/memory model
// predict every write, read address and readback word.
module tb_adc_sdram_capture_client;
  localparam int AW = 22;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Reset, AdcValid, Arm, Arm2, Dump, Dump2, OutReady, OutReady2;
  logic [11:0]   AdcData;
  logic [AW-1:0] CaptureLen;
  logic [15:0]   OutData, OutData2, MemDataOut, MemDataOut2, MemDataIn, MemDataIn2;
  logic          OutValid, OutValid2, Done, Done2, Overflow, Overflow2, Active, Active2;
  logic          MemReq, MemReq2, MemWnR, MemWnR2, MemBusy, MemBusy2, MemAck, MemAck2;
  logic [AW-1:0] MemAddress, MemAddress2;
  logic          ctl_busy, refresh, hold_ack;

  assign MemBusy = ctl_busy | refresh;

  int checks = 0, errors = 0;
  int done_cnt = 0, done2_cnt = 0, req_rises = 0, rdy_mode = 0;
  logic [15:0] mem [int];
  logic [15:0] model [int];
  int          exp_wr_a [$];
  logic [15:0] exp_wr_d [$];
  int          exp_rd_a [$];
  logic [15:0] exp_out [$];
  int          wrap_a [$];
  logic [15:0] wrap_d [$];

  adc_sdram_capture_client dut (
    .Clk(Clk), .Reset(Reset), .AdcData(AdcData), .AdcValid(AdcValid), .Arm(Arm),
    .CaptureLen(CaptureLen), .Dump(Dump), .OutData(OutData), .OutValid(OutValid),
    .OutReady(OutReady), .Done(Done), .Overflow(Overflow), .Active(Active),
    .MemReq(MemReq), .MemWnR(MemWnR), .MemAddress(MemAddress), .MemDataOut(MemDataOut),
    .MemDataIn(MemDataIn), .MemBusy(MemBusy), .MemAck(MemAck)
  );

  adc_sdram_capture_client #(.START_ADDR(22'h3FFFFE)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .AdcData(AdcData), .AdcValid(AdcValid), .Arm(Arm2),
    .CaptureLen(CaptureLen), .Dump(Dump2), .OutData(OutData2), .OutValid(OutValid2),
    .OutReady(OutReady2), .Done(Done2), .Overflow(Overflow2), .Active(Active2),
    .MemReq(MemReq2), .MemWnR(MemWnR2), .MemAddress(MemAddress2), .MemDataOut(MemDataOut2),
    .MemDataIn(MemDataIn2), .MemBusy(MemBusy2), .MemAck(MemAck2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: random ack latency, busy after ack, read data when busy drops.
  initial begin
    int a; logic w; logic [15:0] d;
    ctl_busy = 0; MemAck = 0; MemDataIn = 0;
    forever begin
      @(negedge Clk);
      if (MemReq) begin
        a = int'(MemAddress); w = MemWnR; d = MemDataOut;
        repeat ($urandom_range(1, 3)) begin
          @(negedge Clk);
          if (MemReq) begin
            chk("req_addr_stable", MemAddress, a);
            chk("req_data_stable", {MemWnR, MemDataOut}, {w, d});
          end
        end
        while (hold_ack) @(negedge Clk);
        if (MemReq) begin
          MemAck = 1; ctl_busy = 1;
          if (w) begin
            mem[a] = d;
            if (exp_wr_a.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_write: got addr %0h data %0h expected none", a, d);
            end else begin
              chk("wr_addr", a, exp_wr_a.pop_front());
              chk("wr_data", d, exp_wr_d.pop_front());
            end
          end else begin
            if (exp_rd_a.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_read: got addr %0h expected none", a);
            end else chk("rd_addr", a, exp_rd_a.pop_front());
          end
          @(negedge Clk);
          MemAck = 0;
          repeat ($urandom_range(0, 2)) @(negedge Clk);
          MemDataIn = mem.exists(a) ? mem[a] : 16'h0;
          ctl_busy = 0;
        end
      end
    end
  end

  initial begin
    MemBusy2 = 0; MemAck2 = 0; MemDataIn2 = 0;
    forever begin
      @(negedge Clk);
      if (MemReq2) begin
        wrap_a.push_back(int'(MemAddress2));
        wrap_d.push_back(MemDataOut2);
        @(negedge Clk); MemAck2 = 1; MemBusy2 = 1;
        @(negedge Clk); MemAck2 = 0; MemBusy2 = 0;
      end
    end
  end

  initial forever begin
    @(posedge Clk); #1;
    if (Done)  done_cnt++;
    if (Done2) done2_cnt++;
  end

  initial begin
    logic b, prev;
    prev = 0;
    forever begin
      @(posedge Clk); b = MemBusy; #1;
      if (MemReq && !prev) begin
        req_rises++;
        chk("req_rise_busy_low", b, 0);
      end
      prev = MemReq;
    end
  end

  initial begin
    logic pv, pr; logic [15:0] pd;
    pv = 0; pr = 0; pd = 0;
    forever begin
      @(negedge Clk);
      if (pv && !pr) begin
        chk("out_hold_valid", OutValid, 1);
        chk("out_hold_data", OutData, pd);
      end
      if (OutValid && OutReady) begin
        if (exp_out.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got %0h expected none", OutData);
        end else chk("out_data", OutData, exp_out.pop_front());
      end
      pv = OutValid; pr = OutReady; pd = OutData;
    end
  end

  initial begin
    OutReady = 1;
    forever begin
      @(posedge Clk); #2;
      case (rdy_mode)
        0:       OutReady = 1'b1;
        1:       OutReady = ~OutReady;
        default: OutReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", checks);
    $fatal(1, "watchdog");
  end

  task automatic arm(input int len);
    @(negedge Clk); Arm = 1; CaptureLen = AW'(len);
    @(negedge Clk); Arm = 0;
  endtask

  // Sample i lands at address i; only the first 'keep' are expected in memory.
  task automatic send(input int n, input int keep, input bit fixed, input int gap);
    for (int i = 0; i < n; i++) begin
      logic [11:0] s;
      s = fixed ? 12'(i + 1) : 12'($urandom);
      AdcData = s; AdcValid = 1;
      if (i < keep) begin
        exp_wr_a.push_back(i);
        exp_wr_d.push_back({4'h0, s});
        model[i] = {4'h0, s};
      end
      @(negedge Clk); AdcValid = 0;
      if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge Clk);
    end
  endtask

  task automatic wait_done(input string name, input int start, input int maxc);
    int n;
    n = 0;
    while (done_cnt == start && n < maxc) begin @(negedge Clk); n++; end
    repeat (3) @(negedge Clk);
    chk(name, done_cnt - start, 1);
  endtask

  task automatic drained(input string name);
    chk({name, "_wr_left"}, exp_wr_a.size(), 0);
    chk({name, "_rd_left"}, exp_rd_a.size(), 0);
    chk({name, "_out_left"}, exp_out.size(), 0);
  endtask

  task automatic dump(input int len, input int mode, input int maxc);
    int s;
    rdy_mode = mode;
    for (int i = 0; i < len; i++) begin
      exp_rd_a.push_back(i);
      exp_out.push_back(model.exists(i) ? model[i] : 16'h0);
    end
    s = done_cnt;
    @(negedge Clk); Dump = 1;
    @(negedge Clk); Dump = 0;
    wait_done("dump_done", s, maxc);
    drained("dump");
  endtask

  initial begin
    int s, r0, len, n;
    Reset = 1; AdcData = 0; AdcValid = 0; Arm = 0; Arm2 = 0; Dump = 0; Dump2 = 0;
    OutReady2 = 1; CaptureLen = 0; refresh = 0; hold_ack = 0;
    repeat (3) @(negedge Clk);
    chk("rst_memreq", MemReq, 0);
    chk("rst_memwnr", MemWnR, 0);
    chk("rst_memaddr", MemAddress, 0);
    chk("rst_memdout", MemDataOut, 0);
    chk("rst_outdata", OutData, 0);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_done", Done, 0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_active", Active, 0);
    chk("rst_wrap_addr", MemAddress2, 22'h3FFFFE);
    Reset = 0;

    s = done_cnt; r0 = req_rises;
    @(negedge Clk); Dump = 1; @(negedge Clk); Dump = 0;
    wait_done("dump_empty_done", s, 5);
    chk("dump_empty_noreq", req_rises - r0, 0);

    s = done_cnt; r0 = req_rises;
    arm(0);
    wait_done("arm_zero_done", s, 2);
    chk("arm_zero_noreq", req_rises - r0, 0);

    s = done_cnt;
    arm(4); send(4, 4, 1, 0);
    wait_done("cap4_done", s, 300);
    drained("cap4");
    chk("cap4_no_overflow", Overflow, 0);
    dump(4, 0, 300);
    dump(4, 1, 300);

    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(1, 12);
      s = done_cnt;
      arm(len); send(len, len, 0, 3);
      wait_done("rand_cap_done", s, 800);
      drained("rand_cap");
      dump(len, 2, 800);
    end

    refresh = 1;
    repeat (2) @(negedge Clk);
    s = done_cnt;
    arm(20); send(20, 16, 0, 0);
    chk("refresh_overflow_set", Overflow, 1);
    repeat (15) @(negedge Clk);
    chk("refresh_no_early_done", done_cnt - s, 0);
    refresh = 0;
    wait_done("refresh_done", s, 800);
    drained("refresh");
    chk("refresh_overflow_sticky", Overflow, 1);
    dump(20, 2, 1500);

    hold_ack = 1;
    arm(3); send(1, 1, 0, 0);
    n = 0;
    while (!MemReq && n < 20) begin @(negedge Clk); n++; end
    chk("req_before_reset", MemReq, 1);
    Reset = 1;
    @(posedge Clk); #1;
    chk("rstmid_memreq", MemReq, 0);
    chk("rstmid_active", Active, 0);
    chk("rstmid_overflow", Overflow, 0);
    @(negedge Clk); Reset = 0; hold_ack = 0;
    exp_wr_a.delete(); exp_wr_d.delete();
    s = done_cnt; r0 = req_rises;
    @(negedge Clk); Dump = 1; @(negedge Clk); Dump = 0;
    wait_done("dump_after_reset_done", s, 5);
    chk("dump_after_reset_noreq", req_rises - r0, 0);
    s = done_cnt;
    arm(2); send(2, 2, 0, 1);
    wait_done("post_reset_cap_done", s, 300);
    drained("post_reset_cap");
    dump(2, 1, 300);

    s = done2_cnt;
    @(negedge Clk); Arm2 = 1; CaptureLen = 4;
    @(negedge Clk); Arm2 = 0;
    for (int i = 0; i < 4; i++) begin
      AdcData = 12'(i + 'h10); AdcValid = 1;
      @(negedge Clk); AdcValid = 0;
    end
    n = 0;
    while (done2_cnt == s && n < 200) begin @(negedge Clk); n++; end
    chk("wrap_done", done2_cnt - s, 1);
    chk("wrap_count", wrap_a.size(), 4);
    for (int i = 0; i < 4 && i < wrap_a.size(); i++) begin
      chk("wrap_addr", wrap_a[i], ('h3FFFFE + i) % 'h400000);
      chk("wrap_data", wrap_d[i], 16'(i + 'h10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
